uart_tx: RTL and testbench

Serial transmitter for the UART AXI-Lite peripheral, the transmit-side counterpart of the receive path. It drains bytes from the TX FIFO through that FIFO's asynchronous-read interface: data valid while not empty, and `rd_en` pops. It serializes each byte onto `txd` as a standard 8N1 frame (optionally 8E1), LSB first, with an internal baud counter. It sits between the TX FIFO read port and the top-level `txd` pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_baud_cnt.sv | 35 +++
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and serial line levels.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;
   localparam logic UART_STOP_LEVEL  = 1'b1;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      TX_PARITY = 3'd3,
`endif
      TX_STOP   = 3'd4
   } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// TX FIFO read port, enable and line-side signals of the UART transmitter.
// master is the transmitter side, slave is the FIFO/host side.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tx_en;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  txd;
   logic                  busy;
   logic                  tx_done;

   modport master (
      input  tx_en, fifo_empty, fifo_rd_data,
      output fifo_rd_en, txd, busy, tx_done
   );

   modport slave (
      output tx_en, fifo_empty, fifo_rd_data,
      input  fifo_rd_en, txd, busy, tx_done
   );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, bit_tick marks the last cycle.
// bit_tick_nxt tells whether bit_tick will be high in the following cycle.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic bit_tick,
   output logic bit_tick_nxt
);
   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   assign bit_tick     = (cnt_q == LAST);
   assign bit_tick_nxt = (cnt_d == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and sends 8N1 frames, LSB first.
// Defining UART_TX_PARITY_EN adds an even-parity bit (8E1).
//   state  | meaning
//   IDLE   | line high, waiting for tx_en and a non-empty FIFO
//   START  | start bit (low) for one bit period
//   DATA   | shifting out DATA_WIDTH payload bits
//   PARITY | even parity of the latched byte (parity builds only)
//   STOP   | stop bit (high); may reload directly into START
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_tx_if.master tx
);
   localparam int            IW       = $clog2(DATA_WIDTH) + 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

   uart_tx_state_t        state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  txd_q, txd_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  bit_tick, tick_nxt;
   logic                  frame_end, load;
`ifdef UART_TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   assign frame_end = (state_q == TX_STOP) && bit_tick;
   // Reset gates the pop so nothing is consumed while the block is held.
   assign load = rst_n && ((state_q == TX_IDLE) || frame_end)
                 && tx.tx_en && !tx.fifo_empty;

   assign tx.fifo_rd_en = load;
   assign tx.txd        = txd_q;
   assign tx.busy       = busy_q;
   assign tx.tx_done    = done_q;

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (load || (state_q == TX_IDLE)),
      .bit_tick     (bit_tick),
      .bit_tick_nxt (tick_nxt)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (load) begin
         state_d = TX_START;
         shift_d = tx.fifo_rd_data;
         idx_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = ^tx.fifo_rd_data;
`endif
      end else if (bit_tick) begin
         case (state_q)
            TX_START: state_d = TX_DATA;
            TX_DATA: begin
               if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = TX_PARITY;
`else
                  state_d = TX_STOP;
`endif
               end else begin
                  idx_d   = idx_q + IW'(1);
                  shift_d = shift_q >> 1;
               end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: state_d = TX_STOP;
`endif
            TX_STOP: state_d = TX_IDLE;
            default: state_d = TX_IDLE;
         endcase
      end
   end

   // Line outputs are registered, so they are derived from the next state.
   always_comb begin
      txd_d = UART_IDLE_LEVEL;
      case (state_d)
         TX_START:  txd_d = UART_START_LEVEL;
         TX_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         TX_PARITY: txd_d = par_d;
`endif
         TX_STOP:   txd_d = UART_STOP_LEVEL;
         default:   txd_d = UART_IDLE_LEVEL;
      endcase
      busy_d = (state_d != TX_IDLE);
      done_d = (state_d == TX_STOP) && tick_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= TX_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         txd_q   <= UART_IDLE_LEVEL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, DATA_WIDTH=8.
// Output word checked each cycle is {txd, busy, tx_done, fifo_rd_en}.
module tb_uart_tx;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam logic [10:0] A5_FRAME = 11'h54A;
`else
   localparam int FRAME_BITS = 10;
   localparam logic [10:0] A5_FRAME = 11'h74A;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   uart_tx_if #(.DATA_WIDTH(8)) u_if ();

   uart_tx #(
      .DATA_WIDTH   (8),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tx    (u_if)
   );

   function automatic logic [3:0] outs();
      return {u_if.txd, u_if.busy, u_if.tx_done, u_if.fifo_rd_en};
   endfunction

   // Transmission order: bit 0 is the start bit; unused top bit is 1.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {2'b11, d, 1'b0};
`endif
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_frame(input string tag, input logic [10:0] frame, input bit next_pop,
                              input int drop_at, input int rst_at);
      int  b;
      bit  last;
      for (int k = 1; k <= FRAME_BITS * CPB; k++) begin
         b    = (k - 1) / CPB;
         last = (k == FRAME_BITS * CPB);
         @(negedge clk);
         check($sformatf("%s k%0d", tag, k), outs(), {frame[b], 1'b1, last, last && next_pop});
         if (k == drop_at) u_if.tx_en = 1'b0;
         if (k == rst_at) begin
            rst_n = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      u_if.tx_en = 1'b1;
      u_if.fifo_empty = 1'b0;
      u_if.fifo_rd_data = 8'h55;
      repeat (3) begin
         @(negedge clk);
         check("reset", outs(), 4'b1000);
      end

      u_if.tx_en = 1'b0;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("tx_en_off", outs(), 4'b1000);
      end

      u_if.fifo_rd_data = 8'hA5;
      u_if.tx_en = 1'b1;
      #1 check("a5_pop", outs(), 4'b1001);
      @(posedge clk);
      #1 u_if.fifo_empty = 1'b1;
      check_frame("a5", A5_FRAME, 1'b0, 0, 0);
      @(negedge clk);
      check("a5_idle", outs(), 4'b1000);

      u_if.fifo_rd_data = 8'h00;
      u_if.fifo_empty = 1'b0;
      #1 check("b2b_pop0", outs(), 4'b1001);
      @(posedge clk);
      #1 u_if.fifo_rd_data = 8'hFF;
      check_frame("b2b0", frame_of(8'h00), 1'b1, 0, 0);
      @(posedge clk);
      #1 u_if.fifo_empty = 1'b1;
      check_frame("b2b1", frame_of(8'hFF), 1'b0, 0, 0);
      @(negedge clk);
      check("b2b_idle", outs(), 4'b1000);

      u_if.tx_en = 1'b0;
      u_if.fifo_rd_data = 8'h5A;
      u_if.fifo_empty = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("hold_off", outs(), 4'b1000);
      end
      u_if.tx_en = 1'b1;
      #1 check("drop_pop", outs(), 4'b1001);
      @(posedge clk);
      #1 u_if.fifo_rd_data = 8'h66;
      check_frame("drop", frame_of(8'h5A), 1'b0, 18, 0);
      repeat (4) begin
         @(negedge clk);
         check("drop_idle", outs(), 4'b1000);
      end
      u_if.fifo_empty = 1'b1;
      u_if.tx_en = 1'b1;

      @(negedge clk);
      u_if.fifo_rd_data = 8'h3C;
      u_if.fifo_empty = 1'b0;
      #1 check("rst_pop", outs(), 4'b1001);
      @(posedge clk);
      #1 u_if.fifo_empty = 1'b1;
      check_frame("rst_mid", frame_of(8'h3C), 1'b0, 0, 26);
      u_if.fifo_rd_data = 8'hC3;
      u_if.fifo_empty = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_held", outs(), 4'b1000);
      end
      rst_n = 1'b1;
      #1 check("post_rst_pop", outs(), 4'b1001);
      @(posedge clk);
      #1 u_if.fifo_empty = 1'b1;
      check_frame("post_rst", frame_of(8'hC3), 1'b0, 0, 0);
      @(negedge clk);
      check("post_rst_idle", outs(), 4'b1000);

`ifdef UART_TX_PARITY_EN
      u_if.fifo_rd_data = 8'h07;
      u_if.fifo_empty = 1'b0;
      #1 check("par_pop0", outs(), 4'b1001);
      @(posedge clk);
      #1 u_if.fifo_rd_data = 8'hA5;
      check_frame("par07", 11'h60E, 1'b1, 0, 0);
      @(posedge clk);
      #1 u_if.fifo_empty = 1'b1;
      check_frame("parA5", 11'h54A, 1'b0, 0, 0);
      @(negedge clk);
      check("par_idle", outs(), 4'b1000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
